// File: rtl/mac_frame_arbiter.sv
// Round-robin frame arbiter that shares one MAC control unit between two
// requesters: grants whole frames, streams the tuples through a register stage,
// waits for the MAC result (bounded by a timeout) and returns it to the owner.
module mac_frame_arbiter #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 25,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic                     req0_last,
    input  logic                     req0_mode,
    input  logic [4*DATA_W-1:0]      req0_ops,
    output logic                     req0_ready,
    output logic                     req0_res_valid,
    output logic signed [RES_W-1:0]  req0_res,
    output logic                     req0_err,
    input  logic                     req1_valid,
    input  logic                     req1_last,
    input  logic                     req1_mode,
    input  logic [4*DATA_W-1:0]      req1_ops,
    output logic                     req1_ready,
    output logic                     req1_res_valid,
    output logic signed [RES_W-1:0]  req1_res,
    output logic                     req1_err,
    output logic                     mac_valid_input,
    output logic                     mac_last_input,
    output logic                     mac_mode,
    output logic signed [DATA_W-1:0] mac_num_a,
    output logic signed [DATA_W-1:0] mac_num_b,
    output logic signed [DATA_W-1:0] mac_num_c,
    output logic signed [DATA_W-1:0] mac_num_x,
    input  logic                     mac_valid_output,
    input  logic signed [RES_W-1:0]  mac_final_output,
    output logic                     busy,
    output logic                     grant_id
);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, DELIVER} state_t;

    // The abort fires on the edge where the wait counter would reach TIMEOUT.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic                ptr;
    logic [15:0]         wait_cnt;
    logic                grant_any;
    logic                grant_pick;
    logic                sel_valid;
    logic                sel_last;
    logic [4*DATA_W-1:0] sel_ops;
    logic                accept;
    logic                timed_out;

    // Pick the next owner: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_pick = (req0_valid & req1_valid) ? ptr : req1_valid;
    end

    // Route the owner's tuple and detect handshakes and the wait timeout.
    always_comb begin
        sel_valid = grant_id ? req1_valid : req0_valid;
        sel_last  = grant_id ? req1_last  : req0_last;
        sel_ops   = grant_id ? req1_ops   : req0_ops;
        accept    = (state == STREAM) && sel_valid;
        timed_out = (state == WAIT_RES) && !mac_valid_output && (wait_cnt == TIMEOUT_LAST);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a result strobe outside WAIT_RES is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (grant_any) state_nxt = STREAM;
            STREAM:   if (accept && sel_last) state_nxt = WAIT_RES;
            WAIT_RES: begin
                if (mac_valid_output) begin
                    state_nxt = DELIVER;
                end else if (timed_out) begin
                    state_nxt = IDLE;
                end
            end
            DELIVER:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Handshake, result strobe and status outputs decoded from state.
    always_comb begin
        req0_ready     = (state == STREAM) && !grant_id;
        req1_ready     = (state == STREAM) && grant_id;
        req0_res_valid = (state == DELIVER) && !grant_id;
        req1_res_valid = (state == DELIVER) && grant_id;
        busy           = (state != IDLE);
    end

    // Grant ownership, per-frame MAC mode and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id <= 1'b0;
            mac_mode <= 1'b0;
            ptr      <= 1'b0;
        end else begin
            if (state == IDLE && grant_any) begin
                grant_id <= grant_pick;
                mac_mode <= grant_pick ? req1_mode : req0_mode;
            end
            if (state == DELIVER || timed_out) begin
                ptr <= !grant_id;
            end
        end
    end

    // Launch accepted tuples to the MAC one cycle after the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_valid_input <= 1'b0;
            mac_last_input  <= 1'b0;
            mac_num_a       <= '0;
            mac_num_b       <= '0;
            mac_num_c       <= '0;
            mac_num_x       <= '0;
        end else begin
            mac_valid_input <= accept;
            mac_last_input  <= accept & sel_last;
            if (accept) begin
                mac_num_a <= $signed(sel_ops[4*DATA_W-1 -: DATA_W]);
                mac_num_b <= $signed(sel_ops[3*DATA_W-1 -: DATA_W]);
                mac_num_c <= $signed(sel_ops[2*DATA_W-1 -: DATA_W]);
                mac_num_x <= $signed(sel_ops[DATA_W-1 -: DATA_W]);
            end
        end
    end

    // Count cycles spent waiting for the MAC result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == WAIT_RES) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Capture the result for the owner and flag frames aborted by timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req0_res <= '0;
            req1_res <= '0;
            req0_err <= 1'b0;
            req1_err <= 1'b0;
        end else begin
            req0_err <= timed_out && !grant_id;
            req1_err <= timed_out && grant_id;
            if (state == WAIT_RES && mac_valid_output) begin
                if (grant_id) begin
                    req1_res <= mac_final_output;
                end else begin
                    req0_res <= mac_final_output;
                end
            end
        end
    end

endmodule

// File: doc/mac_frame_arbiter.md
Name: mac_frame_arbiter

Overview:
- Shares one MAC control unit (trinomial sum-of-products datapath, 8-bit signed operands, 25-bit signed result) between two requesters.
- Grants whole frames: a frame is a run of operand tuples ending with last.
- Forwards the granted frame to the MAC, waits for the MAC result, and routes it back to the owning requester.
- Round-robin between requesters; a timeout guards against a missing result.

Parameters:
- DATA_W, 8, width of each operand a/b/c/x (signed).
- RES_W, 25, width of the MAC result (signed).
- TIMEOUT, 255, maximum cycles spent in WAIT_RES before the frame is aborted (1..2^16-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  requester N (N=0,1) tuple valid.
- reqN_last  in  1  requester N tuple is the last of its frame.
- reqN_mode  in  1  requester N MAC mode; sampled at grant only.
- reqN_ops  in  4*DATA_W  requester N operands, packed {a,b,c,x}; a in the MSBs.
- reqN_ready  out  1  requester N tuple accepted when valid&ready.
- reqN_res_valid  out  1  one-cycle pulse: result for requester N.
- reqN_res  out  RES_W  result for requester N; holds its value until the next delivery to N.
- reqN_err  out  1  one-cycle pulse: frame of requester N aborted by timeout.
- mac_valid_input, mac_last_input, mac_mode  out  1  drive the MAC.
- mac_num_a, mac_num_b, mac_num_c, mac_num_x  out  DATA_W  drive the MAC.
- mac_valid_output  in  1  MAC result strobe.
- mac_final_output  in  RES_W  MAC result.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  owner of the current or most recent frame.

Behaviour:
- Reset (async): state IDLE, all outputs 0, priority pointer = requester 0, timeout counter 0.
- Reset mid-frame: the frame is dropped silently, with no err pulse.
- States: IDLE, STREAM, WAIT_RES, DELIVER.
- IDLE:
  - If exactly one reqN_valid, grant N.
  - If both are valid, grant the pointer's requester.
  - On grant: register grant_id, latch mac_mode <= reqN_mode, go to STREAM next cycle.
  - reqN_ready = 0 in IDLE; the pending tuple is not consumed.
- STREAM:
  - reqN_ready = 1 for the granted N only; the other requester's ready = 0.
  - Each accepted tuple is registered onto mac_num_* with mac_valid_input = 1 and mac_last_input = reqN_last. This gives one cycle of latency.
  - Cycles with no acceptance drive mac_valid_input = 0 and mac_last_input = 0; operand buses hold their values.
  - Accepted last -> WAIT_RES next cycle, so ready drops exactly one cycle after the last handshake.
  - mac_mode is constant for the whole frame.
- WAIT_RES:
  - Timeout counter starts at 0 and increments each cycle.
  - mac_valid_output = 1 -> capture mac_final_output, go to DELIVER.
  - Counter reaches TIMEOUT with no strobe -> reqN_err pulse for 1 cycle, pointer <= other requester, go to IDLE.
  - A strobe in the same cycle as the counter reaching TIMEOUT wins; no err pulse.
- DELIVER: reqN_res_valid = 1 for one cycle with the captured result, pointer <= other requester, go to IDLE. Next grant can occur the following cycle.
- mac_valid_output in IDLE, STREAM or DELIVER is ignored; no state change.
- Requester valid dropping mid-frame (before last) keeps the grant; STREAM waits indefinitely.
- Results pass through unchanged; no sign or width conversion.

Test Plan:
- Single frame: req0 sends 3 tuples ({1,2,3,4}, {5,6,7,8}, {-1,-2,-3,-4}, last on the third), mode=1; MAC stub strobes 25'h0001234 four cycles after mac_last_input -> mac_num_* reproduce the tuples, each one cycle after its handshake; mac_mode=1 throughout; req0_res_valid pulses once with 25'h0001234; req1 outputs stay 0.
- Contention: both valid in IDLE after reset -> req0 granted first; req1 granted in the cycle after req0's DELIVER.
- Fairness: the next simultaneous request after that -> req0 wins again; 4 back-to-back contended frames alternate 0,1,0,1.
- Timeout: TIMEOUT=8, MAC stub never strobes -> req1_err pulses exactly 8 cycles after WAIT_RES entry; req1_res_valid never asserts; the next contended grant goes to req0.
- Stray strobe plus tie: mac_valid_output pulsed in IDLE -> no res_valid. With TIMEOUT=8, a strobe in the same cycle the counter reaches 8 -> res_valid asserts and err does not.
- Async reset asserted mid-STREAM after 2 of 3 tuples -> all outputs 0 immediately; after release, req0 priority holds and a new frame completes normally.
